// File: rtl/serial_add_scheduler_pkg.sv
// serial_add_scheduler_pkg: shared state type and datapath widths for the serial add scheduler
package serial_add_scheduler_pkg;
  localparam int OP_W = 4;
  localparam int SUM_W = 5;
  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, RESP} state_t;
endpackage

// File: rtl/serial_add_scheduler_if.sv
// serial_add_scheduler_if: requester, response and adder-control signals of the scheduler
interface serial_add_scheduler_if;
  import serial_add_scheduler_pkg::*;
  logic [1:0] req, ack;
  logic [OP_W-1:0] a0, b0, a1, b1, add_a, add_b;
  logic [SUM_W-1:0] rsp_sum, add_sum;
  logic rsp_valid, rsp_id, rsp_err, add_load, add_start, add_done;
  modport master (
    output req, a0, b0, a1, b1, add_sum, add_done,
    input ack, rsp_valid, rsp_id, rsp_sum, rsp_err, add_load, add_start, add_a, add_b
  );
  modport slave (
    input req, a0, b0, a1, b1, add_sum, add_done,
    output ack, rsp_valid, rsp_id, rsp_sum, rsp_err, add_load, add_start, add_a, add_b
  );
endinterface

// File: rtl/serial_add_scheduler_rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant; on a tie the requester not last served wins
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);
  assign grant = (&req) ? (last ? 2'b01 : 2'b10) : req;
endmodule

// File: rtl/serial_add_scheduler.sv
// serial_add_scheduler: arbitrates two requesters onto a bit-serial adder with timeout abort
module serial_add_scheduler
  import serial_add_scheduler_pkg::*;
#(
  parameter int TIMEOUT = 8
) (
  input logic clk,
  input logic rst_n,
  serial_add_scheduler_if.slave bus
);
  localparam logic [3:0] LIMIT = 4'(TIMEOUT - 1);
  state_t state;
  logic last, id;
  logic [3:0] cnt;
  logic [1:0] grant;
  rr_arbiter2 u_arb (.req(bus.req), .last(last), .grant(grant));
  // rsp_valid rises the cycle after RESP, giving ack-to-response latency of 3 + WAIT cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      last <= 1'b1;
      id <= 1'b0;
      cnt <= '0;
      bus.ack <= '0;
      bus.add_load <= 1'b0;
      bus.add_start <= 1'b0;
      bus.add_a <= '0;
      bus.add_b <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id <= 1'b0;
      bus.rsp_sum <= '0;
      bus.rsp_err <= 1'b0;
    end else begin
      bus.ack <= '0;
      bus.add_load <= 1'b0;
      bus.add_start <= 1'b0;
      bus.rsp_valid <= 1'b0;
      case (state)
        IDLE: if (|grant) begin
          state <= LOAD;
          bus.ack <= grant;
          bus.add_load <= 1'b1;
          id <= grant[1];
          bus.add_a <= grant[1] ? bus.a1 : bus.a0;
          bus.add_b <= grant[1] ? bus.b1 : bus.b0;
        end
        LOAD: begin
          state <= START;
          bus.add_start <= 1'b1;
        end
        START: begin
          state <= WAIT;
          cnt <= '0;
        end
        WAIT: begin
          cnt <= cnt + 4'd1;
          if (bus.add_done || cnt == LIMIT) begin
            state <= RESP;
            bus.rsp_id <= id;
            bus.rsp_sum <= bus.add_done ? bus.add_sum : '0;
            bus.rsp_err <= !bus.add_done;
          end
        end
        RESP: begin
          state <= IDLE;
          bus.rsp_valid <= 1'b1;
          last <= id;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_add_scheduler.sv
// tb_serial_add_scheduler: randomized scoreboard bench with a transaction-level arbitration/adder model
module tb_serial_add_scheduler;
  localparam int TIMEOUT = 8;
  typedef struct {int id; int sum; int err; int lat;} exp_t;
  logic clk = 1'b0, rst_n = 1'b0;
  serial_add_scheduler_if bus ();
  serial_add_scheduler #(.TIMEOUT(TIMEOUT)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  exp_t expq[$];
  logic [1:0] ackq[$];
  int vecs = 0, errs = 0, cyc = 0, ack_cyc = 0, cur_d = 0;
  int last_m = 1;
  int opa[2], opb[2];
  exp_t e;
  logic [1:0] ea;
  // scoreboard monitor
  always @(negedge clk) if (rst_n) begin
    cyc++;
    if (bus.ack != 2'b00) begin
      vecs++;
      ack_cyc = cyc;
      if (ackq.size() == 0) begin
        errs++;
        $display("FAIL ack_unexpected got=%b want=none", bus.ack);
      end else begin
        ea = ackq.pop_front();
        if (bus.ack !== ea || !bus.add_load) begin
          errs++;
          $display("FAIL ack got=%b load=%b want=%b load=1", bus.ack, bus.add_load, ea);
        end
      end
    end
    if (bus.rsp_valid) begin
      vecs++;
      if (expq.size() == 0) begin
        errs++;
        $display("FAIL rsp_unexpected id=%0d sum=%0d err=%0d", bus.rsp_id, bus.rsp_sum, bus.rsp_err);
      end else begin
        e = expq.pop_front();
        if (int'(bus.rsp_id) != e.id || int'(bus.rsp_sum) != e.sum || int'(bus.rsp_err) != e.err
            || cyc - ack_cyc != e.lat) begin
          errs++;
          $display("FAIL rsp got id=%0d sum=%0d err=%0d lat=%0d want id=%0d sum=%0d err=%0d lat=%0d",
                   bus.rsp_id, bus.rsp_sum, bus.rsp_err, cyc - ack_cyc, e.id, e.sum, e.err, e.lat);
        end
      end
    end
  end
  // adder model: completes cur_d cycles into WAIT, never when cur_d is 0
  initial begin
    bus.add_done = 1'b0;
    bus.add_sum = '0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.add_start && cur_d > 0) begin
        repeat (cur_d) @(posedge clk);
        #1;
        if (rst_n) begin
          bus.add_sum = {1'b0, bus.add_a} + {1'b0, bus.add_b};
          bus.add_done = 1'b1;
          @(posedge clk);
          #1;
        end
        bus.add_done = 1'b0;
        bus.add_sum = '0;
      end
    end
  end
  task automatic check_zero(input string tag);
    logic [24:0] o;
    o = {bus.ack, bus.rsp_valid, bus.rsp_id, bus.rsp_sum, bus.rsp_err, bus.add_load, bus.add_start, bus.add_a, bus.add_b};
    vecs++;
    if (o !== '0) begin
      errs++;
      $display("FAIL %s outputs got=%h want=0", tag, o);
    end
  endtask
  task automatic wait_ack(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      ok = bus.ack != 2'b00;
    end
    if (!ok) begin
      vecs++;
      errs++;
      $display("FAIL ack_timeout got=none want=%b", ackq.size() ? ackq[0] : 2'b00);
      ackq.delete();
      expq.delete();
    end
  endtask
  task automatic op(input logic [1:0] raise, input int x0, input int y0, input int x1, input int y1,
                    input int d, input bit tog);
    int w, s;
    bit ok;
    logic [1:0] r;
    if (raise[0] && !bus.req[0]) begin opa[0] = x0; opb[0] = y0; bus.a0 = 4'(x0); bus.b0 = 4'(y0); bus.req[0] = 1'b1; end
    if (raise[1] && !bus.req[1]) begin opa[1] = x1; opb[1] = y1; bus.a1 = 4'(x1); bus.b1 = 4'(y1); bus.req[1] = 1'b1; end
    r = bus.req;
    if (r == 2'b00) begin
      repeat (3) @(negedge clk);
      return;
    end
    w = (r == 2'b11) ? (last_m == 1 ? 0 : 1) : (r[1] ? 1 : 0);
    s = (d == 0) ? 0 : opa[w] + opb[w];
    cur_d = d;
    ackq.push_back(w ? 2'b10 : 2'b01);
    expq.push_back('{w, s, (d == 0) ? 1 : 0, 3 + ((d == 0) ? TIMEOUT : d)});
    wait_ack(ok);
    bus.req[w] = 1'b0;
    last_m = w;
    if (!ok) return;
    if (tog && !bus.req[1-w]) begin
      @(negedge clk);
      @(negedge clk);
      bus.req[1-w] = 1'b1;
      @(negedge clk);
      bus.req[1-w] = 1'b0;
    end
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      #1;
      ok = expq.size() == 0;
    end
    if (!ok) begin
      vecs++;
      errs++;
      $display("FAIL rsp_timeout got=none want=id%0d", w);
      expq.delete();
    end
  endtask
  initial begin
    bit ok;
    bus.req = 2'b00;
    {bus.a0, bus.b0, bus.a1, bus.b1} = '0;
    #12;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    check_zero("post_reset");
    op(2'b01, 13, 11, 0, 0, 4, 1'b0);
    op(2'b11, 3, 4, 15, 15, 2, 1'b0);
    op(2'b00, 0, 0, 0, 0, 1, 1'b0);
    op(2'b01, 9, 6, 0, 0, 0, 1'b0);
    op(2'b10, 0, 0, 0, 0, TIMEOUT, 1'b0);
    op(2'b01, 7, 8, 2, 2, 5, 1'b1);
    op(2'b01, 1, 1, 0, 0, 1, 1'b0);
    // reset pulse during WAIT aborts the operation
    opa[0] = 5; opb[0] = 5; bus.a0 = 4'd5; bus.b0 = 4'd5;
    cur_d = 0;
    ackq.push_back(2'b01);
    bus.req = 2'b01;
    wait_ack(ok);
    bus.req = 2'b00;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero("async_reset");
    repeat (2) @(negedge clk);
    check_zero("in_reset");
    rst_n = 1'b1;
    last_m = 1;
    op(2'b10, 0, 0, 12, 3, 3, 1'b0);
    for (int k = 0; k < 60; k++)
      op(2'($urandom_range(0, 3)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
         int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
         int'($urandom_range(0, TIMEOUT)), 1'($urandom_range(0, 1)));
    bus.req = 2'b00;
    repeat (30) @(negedge clk);
    vecs++;
    if (expq.size() != 0 || ackq.size() != 0) begin
      errs++;
      $display("FAIL drain got=%0d/%0d pending want=0/0", expq.size(), ackq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/serial_add_scheduler.md
SERIAL_ADD_SCHEDULER -- requirements
Module: serial_add_scheduler

Interface
REQ-001 SHALL have one parameter: TIMEOUT, default 8, maximum cycles in WAIT before abort (range 2..15).
REQ-002 SHALL use one clock, clk, and an asynchronous active-low reset, rst_n.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req  input  2  per-requester request level; bit i held high until ack[i] is seen.
REQ-006 a0, b0  input  4 each  requester 0 operands, stable while req[0] is high.
REQ-007 a1, b1  input  4 each  requester 1 operands, stable while req[1] is high.
REQ-008 ack  output  2  one-hot single-cycle pulse; operands of the granted requester are taken this cycle.
REQ-009 rsp_valid  output  1  single-cycle result strobe.
REQ-010 rsp_id  output  1  requester index that owns the response.
REQ-011 rsp_sum  output  5  5-bit sum (a+b, no overflow loss).
REQ-012 rsp_err  output  1  high with rsp_valid when the operation timed out.
REQ-013 add_load, add_start  output  1 each  controls to the bit-serial adder.
REQ-014 add_a, add_b  output  4 each  operands to the adder.
REQ-015 add_sum  input  5  adder result; valid while add_done is high.
REQ-016 add_done  input  1  adder completion level.

Function
REQ-017 FSM states SHALL be IDLE, LOAD, START, WAIT, RESP.
REQ-018 IDLE: if any req bit is high, the FSM SHALL pick the winner by round-robin and go to LOAD; otherwise it stays in IDLE.
REQ-019 Round-robin: the last-served pointer SHALL start at 1, so requester 0 wins first after reset; on simultaneous requests, the requester not last served wins.
REQ-020 LOAD (1 cycle): add_load=1, ack[winner]=1, and add_a/add_b driven from the winner's operands, which are also captured into internal registers.
REQ-021 START (1 cycle): add_start=1; add_a/add_b SHALL hold the captured operands; the timeout counter clears.
REQ-022 WAIT: the timeout counter increments each cycle; on add_done=1, add_sum SHALL be captured and the FSM goes to RESP with err=0.
REQ-023 WAIT: when the counter reaches TIMEOUT without add_done, the FSM SHALL go to RESP with err=1 and rsp_sum=0.
REQ-024 If add_done and the timeout occur in the same cycle, add_done SHALL win (err=0).
REQ-025 RESP (1 cycle): rsp_valid=1 with the captured rsp_id, rsp_sum and rsp_err; the last-served pointer updates; the next state is IDLE.
REQ-026 Latency from the ack cycle to rsp_valid SHALL be 3 + d cycles, where d is WAIT cycles (minimum d=1).
REQ-027 No requester SHALL be granted while an operation is in flight; req changes outside IDLE are ignored.
REQ-028 A requester dropping req before ack SHALL be legal; no grant results if it is low in IDLE.
REQ-029 Throughput: back-to-back service SHALL include one IDLE cycle between RESP and the next LOAD.
REQ-030 add_load, add_start, ack and rsp_valid SHALL be registered outputs, never high together except add_load with ack.

Reset
REQ-031 Reset SHALL force state IDLE, pointer=1, counter=0, and all outputs 0 (ack=2'b00, rsp_sum=5'b0, add_a=add_b=4'b0).
REQ-032 Reset asserted mid-operation SHALL abort it with no rsp_valid; after release, the FSM returns to IDLE and pending req is re-arbitrated.

Structure
REQ-033 A shared package SHALL hold the state enum type, the sum width constant (5) and the operand width constant (4).
REQ-034 The round-robin selection SHALL be one sub-module, rr_arbiter2 (req[1:0], last-served pointer in, one-hot grant out, purely combinational).
REQ-035 The FSM, counter and capture registers SHALL reside in serial_add_scheduler.

Verification
REQ-036 req=01, a0=13, b0=11, adder done after 4 cycles -> ack=01 in LOAD; rsp_valid with rsp_id=0, rsp_sum=24, rsp_err=0, 7 cycles after ack.
REQ-037 req=11 held, a0=3/b0=4, a1=15/b1=15 -> requester 0 served first (sum 7), then requester 1 (sum 30); each ack exactly once.
REQ-038 TIMEOUT=8, add_done never asserted -> rsp_valid after 8 WAIT cycles with rsp_err=1, rsp_sum=0, rsp_id=winner.
REQ-039 rst_n pulsed low during WAIT -> all outputs 0 immediately, no rsp_valid; after release with req=10, ack=10 follows from IDLE.
REQ-040 add_done in the same cycle the counter hits TIMEOUT, a=0, b=0 -> rsp_err=0, rsp_sum=0.
REQ-041 req[1] toggled during WAIT of requester 0 -> no extra ack; requester 1 is served only after RESP plus the IDLE cycle.
